// File: rtl/arp_req_scheduler_pkg.sv
// arp_req_scheduler_pkg: shared ARP opcodes, socket mode code, FSM and grant encodings
package arp_req_scheduler_pkg;

    localparam logic [1:0] ARP_OP_REQ      = 2'b01;
    localparam logic [1:0] ARP_OP_REPLY    = 2'b10;
    localparam logic [3:0] SOCKET_IN_UDPGP = 4'h4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_REQ,
        ST_WAIT_REPLY,
        ST_RESOLVED,
        ST_FAIL_HOLD
    } arp_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_REPLY,
        GNT_REQ,
        GNT_GRAT
    } arp_gnt_e;

endpackage

// File: rtl/arp_ms_timer.sv
// arp_ms_timer: free-running 1 ms tick prescaler plus clearable saturating ms counter
module arp_ms_timer #(
    parameter int TICK_DIV = 125000,
    parameter int W        = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    output logic [W-1:0] ms
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre;
    logic          tick;

    assign tick = (pre == PW'(TICK_DIV - 1));

    // prescaler wraps at TICK_DIV-1, producing one tick per ms
    always_ff @(posedge clk) begin
        if (rst) pre <= '0;
        else     pre <= tick ? '0 : pre + 1'b1;
    end

    // ms counter reloads to zero on clr and saturates at all-ones
    always_ff @(posedge clk) begin
        if (rst || clr)          ms <= '0;
        else if (tick && ms != '1) ms <= ms + 1'b1;
    end

endmodule

// File: rtl/arp_req_scheduler.sv
// arp_req_scheduler: ARP resolver FSM with reply queue and one-outstanding TX arbiter (optional ARP_GRATUITOUS_EN)
module arp_req_scheduler
    import arp_req_scheduler_pkg::*;
#(
    parameter int TICK_DIV     = 125000,
    parameter int RETRY_MS     = 1000,
    parameter int MAX_RETRY    = 4,
    parameter int REFRESH_MS   = 60000,
    parameter int FAIL_HOLD_MS = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] SetDataDstIP,
    input  logic [3:0]  SetWorkProtocol,
    input  logic        ARPReqReced,
    input  logic        ARPReplyReced,
    input  logic [31:0] RecSrcIP,
`ifdef ARP_GRATUITOUS_EN
    input  logic [31:0] SetLocalIP,
`endif
    output logic        TxArpReq,
    output logic [1:0]  TxArpOp,
    output logic [31:0] TxArpTargetIP,
    input  logic        TxArpAck,
    output logic        ArpResolved,
    output logic        ArpResolveFail,
    output logic [2:0]  ArpRetryCnt
);

    arp_state_e  state, nxt;
    arp_gnt_e    gnt, sel;
    logic [31:0] dst_q, rep_ip, ms, local_ip, sel_ip;
    logic [1:0]  sel_op;
    logic        rep_pend, req_pend, grat_pend, ack, go, grp, dst_chg, match;
    logic        restart, wipe, clr, exp_retry, exp_refresh, exp_hold;

    arp_ms_timer #(.TICK_DIV(TICK_DIV), .W(32)) u_tmr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .ms  (ms)
    );

    assign grp         = (SetWorkProtocol == SOCKET_IN_UDPGP);
    assign dst_chg     = (SetDataDstIP != dst_q);
    assign match       = ARPReplyReced && (RecSrcIP == SetDataDstIP);
    assign ack         = TxArpAck && TxArpReq;
    assign exp_retry   = (ms >= 32'(RETRY_MS));
    assign exp_refresh = (ms >= 32'(REFRESH_MS));
    assign exp_hold    = (ms >= 32'(FAIL_HOLD_MS));
    assign wipe        = restart || (nxt == ST_IDLE);
    assign clr         = restart || (nxt != state);

    // pending means waiting for a TX grant; a request already held in TX is not pending again
    assign req_pend = (state == ST_SEND_REQ) && !(TxArpReq && gnt == GNT_REQ);
    assign sel      = rep_pend ? GNT_REPLY : req_pend ? GNT_REQ : grat_pend ? GNT_GRAT : GNT_NONE;
    assign sel_op   = (sel == GNT_REPLY) ? ARP_OP_REPLY : ARP_OP_REQ;
    assign sel_ip   = (sel == GNT_REPLY) ? rep_ip : (sel == GNT_REQ) ? SetDataDstIP : local_ip;
    assign go       = !TxArpReq && (sel != GNT_NONE);

`ifdef ARP_GRATUITOUS_EN
    logic grat_done;
    assign grat_pend = !grat_done;
    assign local_ip  = SetLocalIP;
    // the gratuitous request is offered once per reset, at lowest priority
    always_ff @(posedge clk) begin
        if (rst)                           grat_done <= 1'b0;
        else if (go && sel == GNT_GRAT)    grat_done <= 1'b1;
    end
`else
    assign grat_pend = 1'b0;
    assign local_ip  = '0;
`endif

    // next-state: group mode and destination changes override normal progression; a matching reply beats timeout
    always_comb begin
        nxt     = state;
        restart = 1'b0;
        if (state != ST_IDLE && grp) nxt = ST_IDLE;
        else if (state != ST_IDLE && dst_chg) begin
            nxt     = ST_SEND_REQ;
            restart = 1'b1;
        end else begin
            case (state)
                ST_IDLE:       nxt = grp ? ST_IDLE : ST_SEND_REQ;
                ST_SEND_REQ:   nxt = (ack && gnt == GNT_REQ) ? ST_WAIT_REPLY : ST_SEND_REQ;
                ST_WAIT_REPLY: nxt = match ? ST_RESOLVED : !exp_retry ? ST_WAIT_REPLY :
                                     (ArpRetryCnt < 3'(MAX_RETRY)) ? ST_SEND_REQ : ST_FAIL_HOLD;
                ST_RESOLVED:   nxt = exp_refresh ? ST_SEND_REQ : ST_RESOLVED;
                ST_FAIL_HOLD:  nxt = exp_hold ? ST_SEND_REQ : ST_FAIL_HOLD;
                default:       nxt = ST_IDLE;
            endcase
        end
    end

    // state register and status outputs updated on state entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            dst_q          <= '0;
            ArpResolved    <= 1'b0;
            ArpResolveFail <= 1'b0;
            ArpRetryCnt    <= '0;
        end else begin
            state          <= nxt;
            dst_q          <= SetDataDstIP;
            ArpResolved    <= wipe ? 1'b0 : (nxt == ST_RESOLVED) ? 1'b1 :
                              (nxt == ST_FAIL_HOLD) ? 1'b0 : ArpResolved;
            ArpResolveFail <= wipe ? 1'b0 : (nxt == ST_FAIL_HOLD) ? 1'b1 :
                              (nxt == ST_SEND_REQ) ? 1'b0 : ArpResolveFail;
            ArpRetryCnt    <= wipe ? '0 :
                              (state == ST_SEND_REQ && nxt == ST_WAIT_REPLY) ? ArpRetryCnt + 3'd1 :
                              (nxt == ST_RESOLVED) ? '0 :
                              (state == ST_FAIL_HOLD && nxt == ST_SEND_REQ) ? '0 : ArpRetryCnt;
        end
    end

    // one-deep reply queue: newest incoming request overwrites, granting empties it
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_pend <= 1'b0;
            rep_ip   <= '0;
        end else if (ARPReqReced) begin
            rep_pend <= 1'b1;
            rep_ip   <= RecSrcIP;
        end else if (go && sel == GNT_REPLY) rep_pend <= 1'b0;
    end

    // registered grant, held until a real ack
    always_ff @(posedge clk) begin
        if (rst) begin
            TxArpReq      <= 1'b0;
            TxArpOp       <= 2'b00;
            TxArpTargetIP <= '0;
            gnt           <= GNT_NONE;
        end else if (go) begin
            TxArpReq      <= 1'b1;
            TxArpOp       <= sel_op;
            TxArpTargetIP <= sel_ip;
            gnt           <= sel;
        end else if (ack) begin
            TxArpReq      <= 1'b0;
            gnt           <= GNT_NONE;
        end
    end

endmodule

// File: tb/tb_arp_req_scheduler.sv
// tb_arp_req_scheduler: directed self-checking bench for arp_req_scheduler
module tb_arp_req_scheduler;
    import arp_req_scheduler_pkg::*;

    localparam int TD = 4, RM = 20, MR = 4, RF = 30, FH = 15;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] SetDataDstIP = 32'hC0A80102, RecSrcIP = '0;
    logic [3:0]  SetWorkProtocol = 4'h1;
    logic        ARPReqReced = 1'b0, ARPReplyReced = 1'b0, TxArpAck = 1'b0;
    logic        TxArpReq, ArpResolved, ArpResolveFail;
    logic [1:0]  TxArpOp;
    logic [31:0] TxArpTargetIP;
    logic [2:0]  ArpRetryCnt;
    int          checks = 0, failures = 0;

    arp_req_scheduler #(.TICK_DIV(TD), .RETRY_MS(RM), .MAX_RETRY(MR), .REFRESH_MS(RF), .FAIL_HOLD_MS(FH)) dut (
        .clk             (clk),
        .rst             (rst),
        .SetDataDstIP    (SetDataDstIP),
        .SetWorkProtocol (SetWorkProtocol),
        .ARPReqReced     (ARPReqReced),
        .ARPReplyReced   (ARPReplyReced),
        .RecSrcIP        (RecSrcIP),
        .TxArpReq        (TxArpReq),
        .TxArpOp         (TxArpOp),
        .TxArpTargetIP   (TxArpTargetIP),
        .TxArpAck        (TxArpAck),
        .ArpResolved     (ArpResolved),
        .ArpResolveFail  (ArpResolveFail),
        .ArpRetryCnt     (ArpRetryCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, TxArpReq, 0);
        chk({tag, "_op"}, TxArpOp, 0);
        chk({tag, "_ip"}, TxArpTargetIP, 0);
        chk({tag, "_res"}, ArpResolved, 0);
        chk({tag, "_fail"}, ArpResolveFail, 0);
        chk({tag, "_cnt"}, ArpRetryCnt, 0);
    endtask

    initial begin
        int nreq, last, gap_bad, w, seen;
        repeat (3) nx();
        chk_reset("rst");
        // incoming ARP request coincides with the first resolver request: reply wins
        rst = 1'b0; ARPReqReced = 1'b1; RecSrcIP = 32'hC0A80109;
        nx(); ARPReqReced = 1'b0;
        chk("grant_latency", TxArpReq, 0);
        nx();
        chk("reply_first_req", TxArpReq, 1);
        chk("reply_first_op", TxArpOp, 2'b10);
        chk("reply_first_ip", TxArpTargetIP, 32'hC0A80109);
        TxArpAck = 1'b1;
        nx(); TxArpAck = 1'b0;
        chk("ack_drops_req", TxArpReq, 0);
        nx();
        chk("req_follows_op", TxArpOp, 2'b01);
        chk("req_follows_ip", TxArpTargetIP, 32'hC0A80102);
        TxArpAck = 1'b1;
        nx(); TxArpAck = 1'b0;
        chk("retry_after_ack", ArpRetryCnt, 1);
        // matching reply ~10 ms after ack, after a non-matching one
        repeat (40) nx();
        ARPReplyReced = 1'b1; RecSrcIP = 32'hC0A80177;
        nx(); ARPReplyReced = 1'b0;
        chk("nonmatch_ignored", ArpResolved, 0);
        ARPReplyReced = 1'b1; RecSrcIP = 32'hC0A80102;
        nx(); ARPReplyReced = 1'b0;
        chk("resolved", ArpResolved, 1);
        chk("resolved_cnt", ArpRetryCnt, 0);
        // destination change while resolved
        repeat (5) nx();
        SetDataDstIP = 32'hC0A80103;
        nx();
        chk("dst_chg_unres", ArpResolved, 0);
        nx();
        chk("dst_chg_req", TxArpReq, 1);
        chk("dst_chg_ip", TxArpTargetIP, 32'hC0A80103);
        // no replies: four requests spaced RETRY_MS, then failure
        nreq = 0; last = 0; gap_bad = 0;
        for (int c = 0; c < 600 && !ArpResolveFail; c++) begin
            if (TxArpReq && !TxArpAck) begin
                if (nreq > 0 && (c - last < 76 || c - last > 88)) gap_bad++;
                last = c; nreq++; TxArpAck = 1'b1;
            end else TxArpAck = 1'b0;
            nx();
        end
        TxArpAck = 1'b0;
        chk("retry_requests", nreq, MR);
        chk("retry_spacing_bad", gap_bad, 0);
        chk("fail_set", ArpResolveFail, 1);
        chk("fail_cnt", ArpRetryCnt, MR);
        w = 0;
        while (!TxArpReq && w < 200) begin nx(); w++; end
        chk("fail_hold_gap_ok", (w >= 55 && w <= 66), 1);
        chk("fail_cleared", ArpResolveFail, 0);
        chk("fail_cnt_cleared", ArpRetryCnt, 0);
        TxArpAck = 1'b1;
        nx(); TxArpAck = 1'b0;
        // reply arriving on the very cycle the wait timer expires
        w = 0;
        while (dut.ms != 32'(RM) && w < 200) begin nx(); w++; end
        chk("expiry_reached", dut.ms, RM);
        ARPReplyReced = 1'b1; RecSrcIP = 32'hC0A80103;
        nx(); ARPReplyReced = 1'b0;
        chk("tie_resolved", ArpResolved, 1);
        chk("tie_cnt", ArpRetryCnt, 0);
        // group mode: no requests, incoming requests still answered
        SetWorkProtocol = SOCKET_IN_UDPGP;
        nx();
        chk("grp_unres", ArpResolved, 0);
        seen = 0;
        for (int c = 0; c < 10 * RM * TD; c++) begin
            if (TxArpReq) seen++;
            nx();
        end
        chk("grp_no_req", seen, 0);
        ARPReqReced = 1'b1; RecSrcIP = 32'hC0A80120;
        nx(); ARPReqReced = 1'b0;
        nx();
        chk("grp_reply_op", TxArpOp, 2'b10);
        chk("grp_reply_ip", TxArpTargetIP, 32'hC0A80120);
        ARPReqReced = 1'b1; RecSrcIP = 32'hC0A80121;
        nx(); ARPReqReced = 1'b0;
        chk("held_req", TxArpReq, 1);
        chk("held_ip", TxArpTargetIP, 32'hC0A80120);
        TxArpAck = 1'b1;
        nx(); TxArpAck = 1'b0;
        nx();
        chk("queued_reply_req", TxArpReq, 1);
        chk("queued_reply_ip", TxArpTargetIP, 32'hC0A80121);
        TxArpAck = 1'b1;
        nx(); TxArpAck = 1'b0;
        // reset in the middle of a handshake
        SetWorkProtocol = 4'h1;
        w = 0;
        while (!TxArpReq && w < 20) begin nx(); w++; end
        chk("pre_rst_req", TxArpReq, 1);
        rst = 1'b1;
        nx();
        chk_reset("mid_rst");
        rst = 1'b0; TxArpAck = 1'b1;
        nx(); TxArpAck = 1'b0;
        chk("stray_ack_idle", TxArpReq, 0);
        nx();
        chk("post_rst_req", TxArpReq, 1);
        chk("post_rst_ip", TxArpTargetIP, 32'hC0A80103);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
